clk_div_prog: RTL and testbench



---
 rtl/clk_div_prog.sv | 186 ++++++++++++++++++
 tb/tb_clk_div_prog.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider with boundary-aligned reconfiguration.
// Odd ratios reach exact 50% duty through a half-cycle high extension.
module clk_div_prog #(
    parameter int CNT_W    = 8,
    parameter int DEF_DIV  = 10,
    parameter int DEF_HIGH = 5,
    parameter int DEF_HALF = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic             cfg_half,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             tick,
    output logic             active
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] HIGH_RST = CNT_W'(DEF_HIGH);
    localparam logic             HALF_RST = (DEF_HALF != 0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             half_q, half_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] pdiv_q, pdiv_d;
    logic [CNT_W-1:0] phigh_q, phigh_d;
    logic             phalf_q, phalf_d;
    logic             q_pos_q, q_pos_d;
    logic             tick_q, tick_d;
    logic             err_q, err_d;
    logic             q_neg_q;

    logic cfg_ok;
    logic xfer;
    logic accept;
    logic reject;
    logic last;
    logic boundary;

    assign cfg_ok = (cfg_div >= CNT_W'(2))
                  && (cfg_high != '0)
                  && (cfg_high < cfg_div);
    assign xfer     = cfg_valid && !pend_q;
    assign accept   = xfer && cfg_ok;
    assign reject   = xfer && !cfg_ok;
    assign last     = (cnt_q == (div_q - CNT_W'(1)));
    assign boundary = (state_q == S_RUN) && last;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (boundary && !en) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Counter, configuration and phase datapath
    always_comb begin
        cnt_d   = cnt_q;
        div_d   = div_q;
        high_d  = high_q;
        half_d  = half_q;
        pend_d  = pend_q;
        pdiv_d  = pdiv_q;
        phigh_d = phigh_q;
        phalf_d = phalf_q;
        q_pos_d = 1'b0;
        tick_d  = 1'b0;
        err_d   = reject;
        if (state_q == S_IDLE) begin
            if (accept) begin
                div_d  = cfg_div;
                high_d = cfg_high;
                half_d = cfg_half;
            end
            if (en) begin
                cnt_d   = '0;
                q_pos_d = (high_d != '0);
                tick_d  = 1'b1;
            end
        end else begin
            if (boundary) begin
                cnt_d = '0;
                if (pend_q) begin
                    div_d  = pdiv_q;
                    high_d = phigh_q;
                    half_d = phalf_q;
                    pend_d = 1'b0;
                end
                if (en) begin
                    q_pos_d = (high_d != '0);
                    tick_d  = 1'b1;
                end
            end else begin
                cnt_d   = cnt_q + CNT_W'(1);
                q_pos_d = (cnt_d < high_q);
            end
            // Offers taken while running wait for the next boundary
            if (accept) begin
                pend_d  = 1'b1;
                pdiv_d  = cfg_div;
                phigh_d = cfg_high;
                phalf_d = cfg_half;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            div_q   <= DIV_RST;
            high_q  <= HIGH_RST;
            half_q  <= HALF_RST;
            pend_q  <= 1'b0;
            pdiv_q  <= DIV_RST;
            phigh_q <= HIGH_RST;
            phalf_q <= HALF_RST;
            q_pos_q <= 1'b0;
            tick_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            high_q  <= high_d;
            half_q  <= half_d;
            pend_q  <= pend_d;
            pdiv_q  <= pdiv_d;
            phigh_q <= phigh_d;
            phalf_q <= phalf_d;
            q_pos_q <= q_pos_d;
            tick_q  <= tick_d;
            err_q   <= err_d;
        end
    end

    // Half-cycle delayed copy of the high phase
    always_ff @(negedge clk) begin
        if (rst) begin
            q_neg_q <= 1'b0;
        end else begin
            q_neg_q <= q_pos_q;
        end
    end

    // Outputs; gating the extension with active truncates on reset
    always_comb begin
        active    = (state_q == S_RUN);
        cfg_ready = !pend_q;
        cfg_err   = err_q;
        tick      = tick_q;
        clk_out   = q_pos_q | (half_q & q_neg_q & active);
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Randomized scoreboard bench for clk_div_prog against a time-based
// reference model of the period/high-phase rules.
module tb_clk_div_prog;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [7:0] cfg_div = 8'd0;
    logic [7:0] cfg_high = 8'd0;
    logic       cfg_half = 1'b0;
    logic       cfg_err;
    logic       clk_out;
    logic       tick;
    logic       active;

    clk_div_prog #(
        .CNT_W   (8),
        .DEF_DIV (10),
        .DEF_HIGH(5),
        .DEF_HALF(0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_div  (cfg_div),
        .cfg_high (cfg_high),
        .cfg_half (cfg_half),
        .cfg_err  (cfg_err),
        .clk_out  (clk_out),
        .tick     (tick),
        .active   (active)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit act;
        bit tck;
        bit rdy;
        bit err;
        bit c1;
        bit c2;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;

    // Reference model state: period start time and active/pending config
    int t = 0;
    bit m_run = 0;
    int m_start = 0;
    int c_div = 10;
    int c_high = 5;
    bit c_half = 0;
    bit pend = 0;
    int p_div = 0;
    int p_high = 0;
    bit p_half = 0;

    task automatic chk(input string nm, input logic act, input logic want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%b want=%b", nm, t, act, want);
        end
    endtask

    task automatic model_step();
        int   k;
        bit   bnd;
        bit   ok;
        bit   acc;
        bit   err;
        exp_t e;
        t++;
        err = 0;
        if (rst) begin
            m_run  = 0;
            c_div  = 10;
            c_high = 5;
            c_half = 0;
            pend   = 0;
        end else begin
            k   = t - 1 - m_start;
            bnd = m_run && (k == c_div - 1);
            ok  = (int'(cfg_div) >= 2) && (int'(cfg_high) >= 1)
                  && (int'(cfg_high) < int'(cfg_div));
            acc = cfg_valid && !pend && ok;
            err = cfg_valid && !pend && !ok;
            if (m_run) begin
                if (bnd) begin
                    if (pend) begin
                        c_div  = p_div;
                        c_high = p_high;
                        c_half = p_half;
                        pend   = 0;
                    end
                    if (en) m_start = t;
                    else m_run = 0;
                end
                if (acc) begin
                    pend   = 1;
                    p_div  = int'(cfg_div);
                    p_high = int'(cfg_high);
                    p_half = cfg_half;
                end
            end else begin
                if (acc) begin
                    c_div  = int'(cfg_div);
                    c_high = int'(cfg_high);
                    c_half = cfg_half;
                end
                if (en) begin
                    m_run   = 1;
                    m_start = t;
                end
            end
        end
        k = t - m_start;
        e.act = m_run;
        e.tck = m_run && (k == 0);
        e.rdy = !pend;
        e.err = err;
        e.c1  = m_run && ((k < c_high) || (c_half && k == c_high));
        e.c2  = m_run && (k < c_high);
        sbq.push_back(e);
    endtask

    task automatic step(input logic r, input logic e, input logic v,
                        input int d, input int h, input logic hf);
        @(negedge clk);
        rst       = r;
        en        = e;
        cfg_valid = v;
        cfg_div   = 8'(d);
        cfg_high  = 8'(h);
        cfg_half  = hf;
        @(posedge clk);
        model_step();
    endtask

    task automatic run(input int n, input logic e);
        for (int i = 0; i < n; i++) step(1'b0, e, 1'b0, 0, 0, 1'b0);
    endtask

    // Monitor: compare each cycle's outputs in both clock halves
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("active", active, e.act);
                chk("tick", tick, e.tck);
                chk("cfg_ready", cfg_ready, e.rdy);
                chk("cfg_err", cfg_err, e.err);
                chk("clk_out_hi_half", clk_out, e.c1);
                @(negedge clk);
                #1;
                chk("clk_out_lo_half", clk_out, e.c2);
            end
        end
    end

    initial begin
        bit r;
        bit e;
        bit v;
        e = 1'b0;
        step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 3, 1, 1'b0);
        run(2, 1'b0);
        run(25, 1'b1);
        run(12, 1'b0);
        step(1'b0, 1'b0, 1'b1, 5, 2, 1'b1);
        run(17, 1'b1);
        run(8, 1'b0);
        step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        run(13, 1'b1);
        step(1'b0, 1'b1, 1'b1, 4, 1, 1'b0);
        run(3, 1'b1);
        step(1'b0, 1'b1, 1'b1, 7, 3, 1'b0);
        run(20, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1, 0, 1'b0);
        run(5, 1'b1);
        step(1'b0, 1'b1, 1'b1, 6, 6, 1'b0);
        run(12, 1'b1);
        step(1'b0, 1'b1, 1'b1, 0, 0, 1'b1);
        run(9, 1'b1);
        run(12, 1'b0);
        step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        run(2, 1'b1);
        step(1'b0, 1'b1, 1'b1, 4, 1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
        run(2, 1'b0);
        run(25, 1'b1);
        for (int i = 0; i < 2500; i++) begin
            r = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) e = !e;
            v = ($urandom_range(0, 5) == 0);
            step(r, e, v, $urandom_range(0, 12), $urandom_range(0, 12),
                 1'($urandom_range(0, 1)));
        end
        @(negedge clk);
        #3;
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
